// File: rtl/fetch_mem_arbiter_if.sv
// fetch_mem_arbiter_if
// Bundles the fetch port, the load/store port and the shared memory port of
// the fetch/load-store memory arbiter.
//   master : arbiter view (takes requests and memory responses, drives
//            grants, completions and the memory request)
//   slave  : environment view (requesters plus memory model)
// Signals:
//   if_req/if_addr            fetch request and byte address
//   if_gnt/if_valid/if_rdata  fetch grant, completion pulse, read data
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request and operands
//   ls_gnt/ls_valid/ls_rdata  load/store grant, completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  shared memory request
//   mem_rdata/mem_valid       shared memory response
interface fetch_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_valid;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_valid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_valid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory port, one outstanding transaction at a time, with a response timeout.
// Ports:
//   clk    sole clock, rising edge
//   n_rst  synchronous active-low reset
//   bus    fetch_mem_arbiter_if.master (fetch, load/store and memory ports)
//   busy   high while a transaction is in flight (ISSUE/WAIT)
//   err    one-cycle pulse when a transaction times out
// Parameter:
//   TIMEOUT  wait cycles allowed for mem_valid after issue (1..255)
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> alternate winner on simultaneous requests,
//                                    fetch first after reset
//                       undefined -> fixed priority, load/store beats fetch
//
// state | meaning
// IDLE  | no transaction; accept the next request, grant registered
// ISSUE | memory request presented with latched operands (one cycle)
// WAIT  | request held, counting cycles until mem_valid or timeout
module fetch_mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                n_rst,
    fetch_mem_arbiter_if.master bus,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_ls_q, owner_ls_d;
    logic        if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
    logic        if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;
    logic        win_ls;
    logic        done;
    logic [31:0] done_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    // 1 = load/store is preferred on the next simultaneous request
    logic        pref_ls_q, pref_ls_d;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_ls_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            ls_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            pref_ls_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_ls_q  <= owner_ls_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_valid_q  <= if_valid_d;
            ls_valid_q  <= ls_valid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            pref_ls_q   <= pref_ls_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_ls_d  = owner_ls_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        done        = 1'b0;
        done_rdata  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        pref_ls_d   = pref_ls_q;
        win_ls      = bus.ls_req && (!bus.if_req || pref_ls_q);
`else
        win_ls      = bus.ls_req;
`endif

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    state_d     = ISSUE;
                    cnt_d       = '0;
                    owner_ls_d  = win_ls;
                    if_gnt_d    = !win_ls;
                    ls_gnt_d    = win_ls;
                    mem_req_d   = 1'b1;
                    mem_we_d    = win_ls && bus.ls_we;
                    mem_addr_d  = win_ls ? bus.ls_addr : bus.if_addr;
                    mem_wdata_d = win_ls ? bus.ls_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    pref_ls_d   = !win_ls;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = cnt_q + 8'd1;
            end
            WAIT: begin
                // A response arriving in the terminal-count cycle still wins.
                if (bus.mem_valid) begin
                    done       = 1'b1;
                    done_rdata = (owner_ls_q && mem_we_q) ? '0 : bus.mem_rdata;
                end else if (cnt_q == TIMEOUT_TC) begin
                    done       = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d   = IDLE;
            cnt_d     = '0;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (owner_ls_q) begin
                ls_valid_d = 1'b1;
                ls_rdata_d = done_rdata;
            end else begin
                if_valid_d = 1'b1;
                if_rdata_d = done_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.ls_valid  = ls_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter
// Directed and randomized transactions against a transaction-level model:
// the winner comes from the arbitration rule, completion time from
// min(latency, TIMEOUT) after issue, and read data from the response or zero
// for stores and timeouts.
module tb_fetch_mem_arbiter;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic n_rst;
    logic busy, err;

    always #5 clk = ~clk;

    fetch_mem_arbiter_if bus ();

    fetch_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    int checks = 0;
    int errors = 0;

    // model state
    bit          m_last_ls;
    logic [31:0] m_if_rdata, m_ls_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_last_ls  = 1'b1;
        m_if_rdata = '0;
        m_ls_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd0);
        chk({tag, "_valid"}, {30'b0, bus.if_valid, bus.ls_valid}, 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_ls_rdata"}, bus.ls_rdata, 32'd0);
        chk({tag, "_mem_ctl"}, {30'b0, bus.mem_req, bus.mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_busy_err"}, {30'b0, busy, err}, 32'd0);
    endtask

    function automatic bit model_pick_ls(input bit ri, input bit rl);
        if (!rl) return 1'b0;
        if (!ri) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_ls;
`else
        return 1'b1;
`endif
    endfunction

    // lat: WAIT cycle (counted from issue) in which mem_valid is driven;
    // lat outside 1..TO means the memory never answers in time.
    task automatic run_txn(input bit ri, input bit rl, input bit we,
                           input logic [31:0] ai, input logic [31:0] al,
                           input logic [31:0] wd, input int lat,
                           input logic [31:0] rd, input bit hold);
        bit          wl, tmo;
        int          last_k;
        logic [31:0] exp_rd, exp_addr;

        bus.if_req   = ri;
        bus.if_addr  = ai;
        bus.ls_req   = rl;
        bus.ls_we    = we;
        bus.ls_addr  = al;
        bus.ls_wdata = wd;
        wl = model_pick_ls(ri, rl);
        m_last_ls = wl;
        exp_addr = wl ? al : ai;

        step();
        chk("if_gnt",  {31'b0, bus.if_gnt}, {31'b0, !wl});
        chk("ls_gnt",  {31'b0, bus.ls_gnt}, {31'b0, wl});
        chk("issue_busy_req", {30'b0, busy, bus.mem_req}, 32'd3);
        chk("issue_mem_we", {31'b0, bus.mem_we}, {31'b0, wl && we});
        chk("issue_mem_addr", bus.mem_addr, exp_addr);
        if (wl) chk("issue_mem_wdata", bus.mem_wdata, wd);
        chk("issue_no_valid", {30'b0, bus.if_valid, bus.ls_valid}, 32'd0);
        chk("held_if_rdata", bus.if_rdata, m_if_rdata);
        chk("held_ls_rdata", bus.ls_rdata, m_ls_rdata);
        if (!hold) begin
            bus.if_req  = 1'b0;
            bus.ls_req  = 1'b0;
            bus.if_addr = $urandom;
            bus.ls_addr = $urandom;
        end

        tmo = (lat < 1 || lat > TO);
        last_k = tmo ? TO : lat;
        for (int k = 1; k <= last_k; k++) begin
            step();
            bus.mem_valid = 1'b0;
            chk("wait_gnt_low", {30'b0, bus.if_gnt, bus.ls_gnt}, 32'd0);
            chk("wait_busy_req", {30'b0, busy, bus.mem_req}, 32'd3);
            chk("wait_mem_addr", bus.mem_addr, exp_addr);
            chk("wait_no_done", {29'b0, bus.if_valid, bus.ls_valid, err}, 32'd0);
            bus.mem_rdata = $urandom;
            if (!tmo && k == lat) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = rd;
            end
        end

        step();
        bus.mem_valid = 1'b0;
        exp_rd = (tmo || (wl && we)) ? 32'd0 : rd;
        if (wl) m_ls_rdata = exp_rd;
        else    m_if_rdata = exp_rd;
        chk("done_if_valid", {31'b0, bus.if_valid}, {31'b0, !wl});
        chk("done_ls_valid", {31'b0, bus.ls_valid}, {31'b0, wl});
        chk("done_if_rdata", bus.if_rdata, m_if_rdata);
        chk("done_ls_rdata", bus.ls_rdata, m_ls_rdata);
        chk("done_err", {31'b0, err}, {31'b0, tmo});
        chk("done_busy_req", {30'b0, busy, bus.mem_req}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        n_rst = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        chk_all_zero("reset");

        // fetch, response 3 cycles after issue
        run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 3, 32'h0050_0093, 0);
        // store
        run_txn(0, 1, 1, 32'h0, 32'h40, 32'hDEAD_BEEF, 2, 32'h1234_5678, 0);
        // load
        run_txn(0, 1, 0, 32'h0, 32'h44, 32'h0, 1, 32'hCAFE_F00D, 0);
        // response exactly at the timeout limit still succeeds
        run_txn(1, 0, 0, 32'h20, 32'h0, 32'h0, TO, 32'hA5A5_0001, 0);
        // memory never answers
        run_txn(1, 0, 0, 32'h24, 32'h0, 32'h0, 0, 32'h0, 0);
        // load timeout
        run_txn(0, 1, 0, 32'h0, 32'h48, 32'h0, TO + 1, 32'h0, 0);

        // mem_valid while idle is ignored
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = $urandom;
            step();
            chk("idle_mem_valid_ignored",
                {29'b0, bus.if_valid, bus.ls_valid, busy}, 32'd0);
            chk("idle_if_rdata_held", bus.if_rdata, m_if_rdata);
        end
        bus.mem_valid = 1'b0;

        // reset re-arms the arbitration preference before the contention run
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        model_reset();

        // both requesters held for four back-to-back transactions
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0,
                    $urandom_range(1, 4), $urandom, (i < 3));

        // reset during WAIT, then a late response
        run_txn(0, 1, 0, 32'h0, 32'h60, 32'h0, 1, 32'h7777_0000, 0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h80;
        step();
        bus.if_req = 1'b0;
        step();
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        model_reset();
        chk_all_zero("midreset");
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_valid = 1'b0;
        chk_all_zero("late_valid");
        step();
        chk_all_zero("late_valid2");
        run_txn(1, 0, 0, 32'h84, 32'h0, 32'h0, 2, 32'h1111_2222, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit ri, rl;
            ri = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            if (!ri && !rl) rl = 1'b1;
            run_txn(ri, rl, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom, $urandom_range(0, TO + 2), $urandom, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_mem_arbiter.md
FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for mem_valid after issue; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset; synchronous and active-low.
REQ-004 SHALL have ports if_req input 1 fetch request; if_addr input 32 fetch byte address.
REQ-005 SHALL have ports if_gnt output 1 fetch accepted; if_valid output 1 fetch data ready; if_rdata output 32 fetch data.
REQ-006 SHALL have ports ls_req input 1 load/store request; ls_we input 1 store=1; ls_addr input 32; ls_wdata input 32.
REQ-007 SHALL have ports ls_gnt output 1; ls_valid output 1; ls_rdata output 32 (load data, zero for stores).
REQ-008 SHALL have ports mem_req output 1; mem_we output 1; mem_addr output 32; mem_wdata output 32 toward the shared memory port.
REQ-009 SHALL have ports mem_rdata input 32; mem_valid input 1 from the shared memory port.
REQ-010 SHALL have ports busy output 1 transaction in flight; err output 1 one-cycle timeout pulse.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-012 IDLE: with any request, choose a winner, pulse the winner's gnt for exactly one cycle, latch its addr/we/wdata/owner, go to ISSUE; with no request, stay in IDLE.
REQ-013 gnt SHALL be registered; a requester holds req and its operands stable until gnt; req dropped before gnt is lost without error.
REQ-014 ISSUE (one cycle): mem_req=1 with latched operands; mem_we=0 for fetch owner; go to WAIT.
REQ-015 WAIT: mem_req held at 1 with latched operands; wait counter increments from 0 each cycle.
REQ-016 In WAIT, mem_valid=1 SHALL register mem_rdata into the owner's rdata, pulse the owner's valid for one cycle, and return to IDLE.
REQ-017 Store completion SHALL pulse ls_valid with ls_rdata=0.
REQ-018 Counter reaching TIMEOUT without mem_valid SHALL pulse err, pulse the owner's valid with rdata=0, and return to IDLE.
REQ-019 mem_valid and counter==TIMEOUT in the same cycle SHALL be treated as success (no err).
REQ-020 mem_valid outside WAIT SHALL be ignored.
REQ-021 The next transaction's gnt SHALL come no earlier than the cycle after valid (no overlap, one outstanding max).
REQ-022 busy=1 in ISSUE and WAIT, 0 in IDLE.
REQ-023 if_rdata/ls_rdata SHALL hold their last value between valid pulses.

Reset
REQ-024 n_rst=0 at a clock edge SHALL force IDLE, counter=0, round-robin pointer=fetch-preferred, and all outputs (gnt, valid, rdata, mem_*, busy, err) to 0.
REQ-025 Reset mid-transaction SHALL abandon it: no valid and no err for it afterwards, and a late mem_valid is ignored.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the winner SHALL alternate, with the requester not granted last winning; after reset fetch wins first.
REQ-027 ARB_ROUND_ROBIN_EN undefined: fixed priority, ls always beats if on simultaneous requests.
REQ-028 A single requester SHALL win immediately in either mode.

Verification
REQ-029 Fetch only: if_addr=0x10, mem_valid 3 cycles after ISSUE with rdata=0x00500093 -> if_gnt 1 cycle, if_valid pulse with if_rdata=0x00500093, busy low afterward.
REQ-030 Store: ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF during ISSUE/WAIT; ls_valid pulse with ls_rdata=0.
REQ-031 Both requesters held high for 4 transactions -> with ARB_ROUND_ROBIN_EN grants are if,ls,if,ls; without it, ls,ls,ls,ls.
REQ-032 TIMEOUT=5, mem_valid never asserted -> err pulse and if_valid with rdata=0 exactly 5 WAIT cycles after ISSUE; then IDLE.
REQ-033 n_rst=0 for one cycle during WAIT, then mem_valid=1 -> no valid/err pulse, all outputs 0, next request served normally.
